// File: rtl/spi_pkg.sv
// spi_pkg: shared state type, synchronizer depth and sample-edge helper
// for the SPI receive FIFO (optional feature macro: SPI_RX_TIMEOUT_EN).
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT      = 2'd1,
        ST_DRAIN_WAIT = 2'd2
    } spi_rx_state_t;

    localparam int SYNC_STAGES = 2;

    // SCLK edge that samples COPI: rising when CPOL equals CPHA.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return ((cpol != 0) == (cpha != 0));
    endfunction

endpackage

// File: rtl/spi_rx_fifo_if.sv
// spi_rx_fifo_if: consumer-side read port of the SPI receive FIFO.
// master drives data/valid/occupancy, slave returns the pop request.
interface spi_rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);

    logic [DATA_W-1:0]            rd_data;
    logic                         rd_valid;
    logic                         rd_ready;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (
        output rd_data,
        output rd_valid,
        output fifo_count,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        output rd_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-two depth.
// A push into a full FIFO is only accepted when a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign valid    = !empty;
    assign count    = cnt;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: SPI target receiver feeding a FWFT FIFO.
// Optional macro SPI_RX_TIMEOUT_EN adds a stalled-frame timeout.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           SCLK,
    input  logic           COPI,
    input  logic           spi_cs_n,
    input  logic           rx_enable,
    spi_rx_fifo_if.master  rd,
    output logic           overrun,
    output logic           frame_abort,
    input  logic           err_clr
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic IDLE_SCLK = (CPOL != 0);
    localparam logic ON_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   copi_s;
    logic                   cs_s;
    logic                   sample_edge;

    spi_rx_state_t     state;
    spi_rx_state_t     state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] word;
    logic              push;
    logic              abort;
    logic              drop;
    logic              timeout;
    logic              to_lock;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign word   = {shreg[DATA_W-2:0], copi_s};

    assign sample_edge = ON_RISE ? (sclk_s && !sclk_prev)
                                 : (!sclk_s && sclk_prev);

    // Pin synchronizers plus a delayed SCLK copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            copi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= IDLE_SCLK;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_s;
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            counting;

    assign counting = (state != ST_IDLE) && (bit_cnt != '0)
                      && !sample_edge && !cs_s;
    assign timeout  = counting && (to_cnt == TO_LAST);

    // Consecutive cycles of a started frame with no sample edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!counting || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // After a timeout, stay out of SHIFT until CS is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_lock <= 1'b0;
        end else if (timeout) begin
            to_lock <= 1'b1;
        end else if (cs_s) begin
            to_lock <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign to_lock = 1'b0;
`endif

    // Receiver state, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shreg       <= shreg_nxt;
            frame_abort <= abort;
        end
    end

    // Frame sequencing: shift on sample edges, push full words,
    // abort partial words on CS release or timeout.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        push        = 1'b0;
        abort       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!cs_s && rx_enable && !to_lock) begin
                    state_nxt   = ST_SHIFT;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = '0;
                end
            end
            ST_SHIFT, ST_DRAIN_WAIT: begin
                if (cs_s) begin
                    abort       = (bit_cnt != '0);
                    state_nxt   = ST_IDLE;
                    bit_cnt_nxt = '0;
                end else if (timeout) begin
                    abort       = 1'b1;
                    state_nxt   = ST_IDLE;
                    bit_cnt_nxt = '0;
                end else begin
                    if (sample_edge) begin
                        shreg_nxt = word;
                        if (bit_cnt == LAST_BIT) begin
                            push        = 1'b1;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                    if (!rx_enable || state == ST_DRAIN_WAIT) begin
                        state_nxt = (bit_cnt_nxt == '0) ? ST_IDLE
                                                        : ST_DRAIN_WAIT;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    // Sticky overrun; a new drop wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word),
        .pop       (rd.rd_ready),
        .pop_data  (rd.rd_data),
        .valid     (rd.rd_valid),
        .count     (rd.fifo_count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed and randomized checks of spi_rx_fifo
// in all four SPI modes and with 8- and 16-bit frames.
module tb_spi_rx_fifo;

    localparam int H = 40;

    logic       clk;
    logic       rst_n;
    logic [4:0] sclk_p;
    logic [4:0] copi_p;
    logic [4:0] cs_p;
    logic       rx_enable;
    logic       err_clr;
    logic [4:0] ovr;
    logic [4:0] fab;

    int nvec = 0;
    int nerr = 0;
    int abort_cnt = 0;
    int abort_run = 0;
    int abort_max = 0;

    spi_rx_fifo_if #(.DATA_W(8),  .FIFO_DEPTH(4)) if0 ();
    spi_rx_fifo_if #(.DATA_W(8),  .FIFO_DEPTH(4)) if1 ();
    spi_rx_fifo_if #(.DATA_W(8),  .FIFO_DEPTH(4)) if2 ();
    spi_rx_fifo_if #(.DATA_W(8),  .FIFO_DEPTH(4)) if3 ();
    spi_rx_fifo_if #(.DATA_W(16), .FIFO_DEPTH(4)) if4 ();

    spi_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0),
                  .TIMEOUT_CYCLES(100)) u0 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[0]), .COPI(copi_p[0]),
        .spi_cs_n(cs_p[0]), .rx_enable(rx_enable), .rd(if0),
        .overrun(ovr[0]), .frame_abort(fab[0]), .err_clr(err_clr));

    spi_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(1),
                  .TIMEOUT_CYCLES(100)) u1 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[1]), .COPI(copi_p[1]),
        .spi_cs_n(cs_p[1]), .rx_enable(rx_enable), .rd(if1),
        .overrun(ovr[1]), .frame_abort(fab[1]), .err_clr(err_clr));

    spi_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(1), .CPHA(0),
                  .TIMEOUT_CYCLES(100)) u2 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[2]), .COPI(copi_p[2]),
        .spi_cs_n(cs_p[2]), .rx_enable(rx_enable), .rd(if2),
        .overrun(ovr[2]), .frame_abort(fab[2]), .err_clr(err_clr));

    spi_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1),
                  .TIMEOUT_CYCLES(100)) u3 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[3]), .COPI(copi_p[3]),
        .spi_cs_n(cs_p[3]), .rx_enable(rx_enable), .rd(if3),
        .overrun(ovr[3]), .frame_abort(fab[3]), .err_clr(err_clr));

    spi_rx_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0),
                  .TIMEOUT_CYCLES(100)) u4 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[4]), .COPI(copi_p[4]),
        .spi_cs_n(cs_p[4]), .rx_enable(rx_enable), .rd(if4),
        .overrun(ovr[4]), .frame_abort(fab[4]), .err_clr(err_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_abort cycles of u0 and longest pulse.
    always @(posedge clk) begin
        if (fab[0]) begin
            abort_cnt <= abort_cnt + 1;
            abort_run <= abort_run + 1;
            if (abort_run + 1 > abort_max) abort_max <= abort_run + 1;
        end else begin
            abort_run <= 0;
        end
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic spi_send(input int idx, input int nbits,
                            input logic [31:0] val, input bit cpol,
                            input bit cpha, input bit finish);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                copi_p[idx] = val[i];
                #(H);
                sclk_p[idx] = ~cpol;
                if (i == 0 && !finish) return;
                #(H);
                sclk_p[idx] = cpol;
            end else begin
                sclk_p[idx] = ~cpol;
                copi_p[idx] = val[i];
                #(H);
                sclk_p[idx] = cpol;
                #(H);
            end
        end
    endtask

    task automatic send_frame(input int idx, input int nbits,
                              input logic [31:0] val, input bit cpol,
                              input bit cpha);
        @(negedge clk);
        cs_p[idx] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(idx, nbits, val, cpol, cpha, 1'b1);
        #(H);
        cs_p[idx] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop0();
        @(negedge clk);
        if0.rd_ready = 1'b1;
        @(negedge clk);
        if0.rd_ready = 1'b0;
    endtask

    task automatic pop4();
        @(negedge clk);
        if4.rd_ready = 1'b1;
        @(negedge clk);
        if4.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec += 5;
        if (if0.rd_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_valid: got %b want 0", if0.rd_valid);
        end
        if (if0.rd_data !== 8'h00) begin
            nerr++; $display("FAIL reset_data: got %h want 00", if0.rd_data);
        end
        if (if0.fifo_count !== 3'd0) begin
            nerr++; $display("FAIL reset_count: got %0d want 0", if0.fifo_count);
        end
        if (ovr[0] !== 1'b0) begin
            nerr++; $display("FAIL reset_overrun: got %b want 0", ovr[0]);
        end
        if (fab[0] !== 1'b0) begin
            nerr++; $display("FAIL reset_abort: got %b want 0", fab[0]);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mode0();
        int lat;
        int a0;
        a0 = abort_cnt;
        lat = 99;
        @(negedge clk);
        cs_p[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 8, 32'hA5, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (if0.rd_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        nvec++;
        if (lat > 5) begin
            nerr++; $display("FAIL mode0_latency: got %0d clk want <=5", lat);
        end
        nvec++;
        if (if0.rd_data !== 8'hA5) begin
            nerr++; $display("FAIL mode0_data: got %h want a5", if0.rd_data);
        end
        sclk_p[0] = 1'b0;
        #(H);
        cs_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        nvec++;
        if (abort_cnt !== a0) begin
            nerr++; $display("FAIL mode0_abort: got %0d want %0d", abort_cnt, a0);
        end
        pop0();
    endtask

    task automatic test_modes();
        send_frame(1, 8, 32'h3C, 1'b0, 1'b1);
        send_frame(2, 8, 32'h3C, 1'b1, 1'b0);
        send_frame(3, 8, 32'h3C, 1'b1, 1'b1);
        nvec += 3;
        if (if1.rd_valid !== 1'b1 || if1.rd_data !== 8'h3C) begin
            nerr++; $display("FAIL mode1_data: got %h want 3c", if1.rd_data);
        end
        if (if2.rd_valid !== 1'b1 || if2.rd_data !== 8'h3C) begin
            nerr++; $display("FAIL mode2_data: got %h want 3c", if2.rd_data);
        end
        if (if3.rd_valid !== 1'b1 || if3.rd_data !== 8'h3C) begin
            nerr++; $display("FAIL mode3_data: got %h want 3c", if3.rd_data);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int w = 1; w <= 5; w++) begin
            send_frame(0, 8, 32'(w), 1'b0, 1'b0);
        end
        nvec += 2;
        if (if0.fifo_count !== 3'd4) begin
            nerr++; $display("FAIL ovr_count: got %0d want 4", if0.fifo_count);
        end
        if (ovr[0] !== 1'b1) begin
            nerr++; $display("FAIL ovr_flag: got %b want 1", ovr[0]);
        end
        for (int w = 1; w <= 4; w++) begin
            exp = 8'(w);
            nvec++;
            if (if0.rd_valid !== 1'b1 || if0.rd_data !== exp) begin
                nerr++;
                $display("FAIL ovr_pop: got %h want %h", if0.rd_data, exp);
            end
            pop0();
        end
        nvec++;
        if (if0.fifo_count !== 3'd0) begin
            nerr++; $display("FAIL ovr_empty: got %0d want 0", if0.fifo_count);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        nvec++;
        if (ovr[0] !== 1'b0) begin
            nerr++; $display("FAIL ovr_clear: got %b want 0", ovr[0]);
        end
    endtask

    task automatic test_abort();
        int a0;
        a0 = abort_cnt;
        @(negedge clk);
        cs_p[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 3, 32'h5, 1'b0, 1'b0, 1'b1);
        #(H);
        cs_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        nvec += 3;
        if (abort_cnt !== a0 + 1) begin
            nerr++; $display("FAIL abort_pulse: got %0d want %0d", abort_cnt - a0, 1);
        end
        if (abort_max !== 1) begin
            nerr++; $display("FAIL abort_width: got %0d want 1", abort_max);
        end
        if (if0.fifo_count !== 3'd0) begin
            nerr++; $display("FAIL abort_count: got %0d want 0", if0.fifo_count);
        end
        send_frame(0, 8, 32'h7E, 1'b0, 1'b0);
        nvec++;
        if (if0.rd_valid !== 1'b1 || if0.rd_data !== 8'h7E) begin
            nerr++; $display("FAIL abort_next: got %h want 7e", if0.rd_data);
        end
        pop0();
    endtask

    task automatic test_back_to_back();
        send_frame(4, 32, 32'h1234_BEEF, 1'b0, 1'b0);
        nvec += 3;
        if (if4.fifo_count !== 3'd2) begin
            nerr++; $display("FAIL b2b_count: got %0d want 2", if4.fifo_count);
        end
        if (if4.rd_data !== 16'h1234) begin
            nerr++; $display("FAIL b2b_first: got %h want 1234", if4.rd_data);
        end
        pop4();
        if (if4.rd_valid !== 1'b1 || if4.rd_data !== 16'hBEEF) begin
            nerr++; $display("FAIL b2b_second: got %h want beef", if4.rd_data);
        end
        pop4();
    endtask

    task automatic test_drain();
        int a0;
        a0 = abort_cnt;
        @(negedge clk);
        cs_p[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 4, 32'h9, 1'b0, 1'b0, 1'b1);
        rx_enable = 1'b0;
        spi_send(0, 4, 32'h6, 1'b0, 1'b0, 1'b1);
        #(H);
        spi_send(0, 8, 32'hFF, 1'b0, 1'b0, 1'b1);
        #(H);
        cs_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        rx_enable = 1'b1;
        nvec += 3;
        if (if0.fifo_count !== 3'd1) begin
            nerr++; $display("FAIL drain_count: got %0d want 1", if0.fifo_count);
        end
        if (if0.rd_data !== 8'h96) begin
            nerr++; $display("FAIL drain_data: got %h want 96", if0.rd_data);
        end
        if (abort_cnt !== a0) begin
            nerr++; $display("FAIL drain_abort: got %0d want %0d", abort_cnt, a0);
        end
        pop0();
    endtask

    task automatic test_timeout();
        int a0;
        int exp;
`ifdef SPI_RX_TIMEOUT_EN
        exp = 1;
`else
        exp = 0;
`endif
        a0 = abort_cnt;
        @(negedge clk);
        cs_p[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 4, 32'hA, 1'b0, 1'b0, 1'b1);
        repeat (150) @(negedge clk);
        nvec++;
        if (abort_cnt - a0 !== exp) begin
            nerr++; $display("FAIL timeout_pulse: got %0d want %0d", abort_cnt - a0, exp);
        end
        cs_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        nvec += 2;
        if (abort_cnt - a0 !== 1) begin
            nerr++; $display("FAIL timeout_total: got %0d want 1", abort_cnt - a0);
        end
        if (if0.fifo_count !== 3'd0) begin
            nerr++; $display("FAIL timeout_count: got %0d want 0", if0.fifo_count);
        end
    endtask

    task automatic test_reset_midframe();
        int a0;
        send_frame(0, 8, 32'h11, 1'b0, 1'b0);
        send_frame(0, 8, 32'h22, 1'b0, 1'b0);
        a0 = abort_cnt;
        @(negedge clk);
        cs_p[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 3, 32'h3, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nvec += 2;
        if (if0.fifo_count !== 3'd0 || if0.rd_valid !== 1'b0) begin
            nerr++; $display("FAIL rstmid_flush: got %0d want 0", if0.fifo_count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        if (abort_cnt !== a0) begin
            nerr++; $display("FAIL rstmid_abort: got %0d want %0d", abort_cnt, a0);
        end
        send_frame(0, 8, 32'h5A, 1'b0, 1'b0);
        nvec++;
        if (if0.rd_valid !== 1'b1 || if0.rd_data !== 8'h5A) begin
            nerr++; $display("FAIL rstmid_next: got %h want 5a", if0.rd_data);
        end
        pop0();
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] w;
        bit         ov;
        int         a0;
        int         ea;
        int         nb;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        ov = 1'b0;
        for (int it = 0; it < 24; it++) begin
            a0 = abort_cnt;
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(1, 7);
                send_frame(0, nb, 32'(w), 1'b0, 1'b0);
                ea = 1;
            end else begin
                send_frame(0, 8, 32'(w), 1'b0, 1'b0);
                ea = 0;
                if (q.size() < 4) q.push_back(w);
                else ov = 1'b1;
            end
            nvec += 3;
            if (if0.fifo_count !== 3'(q.size())) begin
                nerr++;
                $display("FAIL rnd_count: got %0d want %0d", if0.fifo_count, q.size());
            end
            if (ovr[0] !== ov) begin
                nerr++; $display("FAIL rnd_overrun: got %b want %b", ovr[0], ov);
            end
            if (abort_cnt - a0 !== ea) begin
                nerr++; $display("FAIL rnd_abort: got %0d want %0d", abort_cnt - a0, ea);
            end
            for (int p = $urandom_range(0, 3); p > 0; p--) begin
                nvec++;
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    if (if0.rd_valid !== 1'b1 || if0.rd_data !== exp) begin
                        nerr++;
                        $display("FAIL rnd_pop: got %h want %h", if0.rd_data, exp);
                    end
                end else if (if0.rd_valid !== 1'b0) begin
                    nerr++; $display("FAIL rnd_empty: got %b want 0", if0.rd_valid);
                end
                pop0();
            end
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                ov = 1'b0;
                nvec++;
                if (ovr[0] !== 1'b0) begin
                    nerr++; $display("FAIL rnd_clear: got %b want 0", ovr[0]);
                end
            end
        end
    endtask

    initial begin
        sclk_p    = 5'b01100;
        copi_p    = 5'b00000;
        cs_p      = 5'b11111;
        rx_enable = 1'b1;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        if0.rd_ready = 1'b0;
        if1.rd_ready = 1'b0;
        if2.rd_ready = 1'b0;
        if3.rd_ready = 1'b0;
        if4.rd_ready = 1'b0;
        test_reset();
        test_mode0();
        test_modes();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_drain();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
